ps2_keyboard_rx: RTL and testbench

Receives PS/2 keyboard frames from the board's ps2_clk/ps2_data pins and validates the framing and parity of each one. Valid scan-code bytes are queued in a small FIFO. This is the input-side counterpart to the display path: a consumer drains bytes and forwards them to seg_hex/ledr. It runs on the system clock and samples the slow PS/2 clock as ordinary data; the PS/2 clock is never used as a clock.

---
 rtl/ps2_keyboard_rx.sv | 118 +++++++++++
 tb/tb_ps2_keyboard_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: oversamples ps2_clk/ps2_data on the system clock,
// checks start/parity/stop framing and queues valid scan codes in a FIFO.
module ps2_keyboard_rx #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0]    clk_sync_q, data_sync_q;
   logic [3:0]    cnt_q;
   logic [9:0]    bits_q;
   logic [TW-1:0] to_cnt_q;
   logic          frame_err_q, overflow_q;
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic fall, bit_in, frame_done, frame_ok, timeout;
   logic empty, full, pop, push, drop;

   // Edge detect, frame completion and FIFO handshake decode
   always_comb begin
      fall       = clk_sync_q[2] & ~clk_sync_q[1];
      bit_in     = data_sync_q[1];
      frame_done = fall && (cnt_q == 4'd10);
      // bit_in is the stop bit when frame_done is asserted
      frame_ok   = ~bits_q[0] & bit_in & (^bits_q[9:1]);
      timeout    = !fall && (cnt_q != 4'd0) && (to_cnt_q == TW'(TIMEOUT_CYCLES));
      empty      = (wr_ptr_q == rd_ptr_q);
      full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop        = ~empty & ~nextdata_n;
      // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
      push       = frame_done & frame_ok & (~full | pop);
      drop       = frame_done & frame_ok & full & ~pop;
   end

   // Three-flop synchronisers; reset to idle-high so no false edge after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q  <= 3'b111;
         data_sync_q <= 3'b111;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
         data_sync_q <= {data_sync_q[1:0], ps2_data};
      end
   end

   // Bit shifter, frame checker and mid-frame timeout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= 4'd0;
         bits_q      <= 10'd0;
         to_cnt_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (fall) begin
            to_cnt_q <= '0;
            if (cnt_q == 4'd10) begin
               cnt_q       <= 4'd0;
               frame_err_q <= ~frame_ok;
            end else begin
               bits_q[cnt_q] <= bit_in;
               cnt_q         <= cnt_q + 4'd1;
            end
         end else if (timeout) begin
            cnt_q       <= 4'd0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b1;
         end else if (cnt_q != 4'd0) begin
            to_cnt_q <= to_cnt_q + TW'(1);
         end
      end
   end

   // FIFO storage and pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bits_q[8:1];
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Sticky overflow: set on a dropped byte, cleared by the next pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (pop) begin
         overflow_q <= 1'b0;
      end
   end

   assign data      = mem_q[rd_ptr_q[AW-1:0]];
   assign ready     = ~empty;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: framing, parity, overflow, timeout, reset.
module tb_ps2_keyboard_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready, overflow, frame_err;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   int e0;

   ps2_keyboard_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(20000)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .nextdata_n(nextdata_n),
      .data      (data),
      .ready     (ready),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // frame_err is a one-cycle pulse, so each pulse is seen at exactly one negedge
   always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame with odd parity; flip=1 corrupts the parity bit
   function automatic logic [10:0] mk(input logic [7:0] b, input logic flip);
      return {1'b1, (~^b) ^ flip, b, 1'b0};
   endfunction

   task automatic bit_fall(input logic b);
      ps2_data = b;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
   endtask

   task automatic bit_rise();
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         bit_fall(f[i]);
         bit_rise();
      end
   endtask

   task automatic pop_byte();
      @(negedge clk) nextdata_n = 1'b0;
      @(negedge clk) nextdata_n = 1'b1;
   endtask

   initial begin
      // Reset values
      #12;
      check("rst_ready", 32'(ready), 0);
      check("rst_data", 32'(data), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);

      // Single frame 0x1C with latency bound on the stop bit
      send_frame(11'b1_0_00011100_0, 10);
      bit_fall(1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("lat_ready", 32'(ready), 1);
      check("lat_data", 32'(data), 32'h1C);
      bit_rise();
      pop_byte();
      check("pop_ready", 32'(ready), 0);
      check("good_no_err", 32'(err_cnt), 0);

      // Parity error, then a good 0xF0
      e0 = err_cnt;
      send_frame(11'b1_1_00011100_0, 11);
      check("par_err", 32'(err_cnt), 32'(e0 + 1));
      check("par_ready", 32'(ready), 0);
      send_frame(11'b1_1_11110000_0, 11);
      check("f0_ready", 32'(ready), 1);
      check("f0_data", 32'(data), 32'hF0);
      pop_byte();

      // Fill with 0x01..0x09; 0x09 is dropped
      for (int i = 1; i <= 9; i++) send_frame(mk(8'(i), 1'b0), 11);
      check("fill_ready", 32'(ready), 1);
      check("fill_data", 32'(data), 32'h01);
      check("fill_ovf", 32'(overflow), 1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_data%0d", i), 32'(data), 32'(i));
         pop_byte();
         if (i == 1) check("ovf_cleared", 32'(overflow), 0);
      end
      check("drain_empty", 32'(ready), 0);

      // Timeout: 5 bits then idle
      e0 = err_cnt;
      send_frame(11'b1_0_00011100_0, 5);
      repeat (19000) @(negedge clk);
      check("to_early", 32'(err_cnt), 32'(e0));
      repeat (1500) @(negedge clk);
      check("to_err", 32'(err_cnt), 32'(e0 + 1));
      send_frame(11'b1_0_00011100_0, 11);
      check("to_ready", 32'(ready), 1);
      check("to_data", 32'(data), 32'h1C);
      pop_byte();

      // Push and pop in the same cycle while full
      for (int i = 1; i <= 8; i++) send_frame(mk(8'(i), 1'b0), 11);
      send_frame(mk(8'h09, 1'b0), 10);
      bit_fall(1'b1);
      // Push lands on the third rising edge after the raw fall
      @(negedge clk);
      @(negedge clk) nextdata_n = 1'b0;
      @(negedge clk) nextdata_n = 1'b1;
      bit_rise();
      check("sim_ovf", 32'(overflow), 0);
      for (int i = 2; i <= 9; i++) begin
         check($sformatf("sim_data%0d", i), 32'(data), 32'(i));
         pop_byte();
      end
      check("sim_empty", 32'(ready), 0);

      // Async reset after 6 bits with a byte queued
      send_frame(mk(8'h05, 1'b0), 11);
      check("pre_rst_ready", 32'(ready), 1);
      send_frame(11'b1_0_00011100_0, 6);
      bit_fall(1'b0);
      #3 rst = 1'b0;
      #1;
      check("arst_ready", 32'(ready), 0);
      check("arst_data", 32'(data), 0);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_empty", 32'(ready), 0);
      send_frame(11'b1_0_00011100_0, 11);
      check("post_rst_ready", 32'(ready), 1);
      check("post_rst_data", 32'(data), 32'h1C);
      pop_byte();
      check("post_rst_pop", 32'(ready), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
